// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the 4:1 data-flow mux selects, with hold timeout
// and a one-cycle break-before-make gap between owners.
module rr_mux_sel_arbiter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       sel1,
    output logic       sel0,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       sel, sel_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [3:0]       grant_nxt;
    logic             valid_nxt, timeout_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       win, cand;
    logic             win_ok;

    // Search ptr+1, ptr+2, ... mod 4; the last owner is checked last.
    always_comb begin
        win    = ptr;
        win_ok = 1'b0;
        cand   = ptr;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win    = cand;
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        grant_nxt   = grant;
        valid_nxt   = valid;
        timeout_nxt = 1'b0;
        case (state)
            IDLE, GAP: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                grant_nxt = 4'b0000;
                if (win_ok) begin
                    state_nxt = GRANT;
                    sel_nxt   = win;
                    ptr_nxt   = win;
                    grant_nxt = 4'b0001 << win;
                    valid_nxt = 1'b1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            GRANT: begin
                if (done || !req[sel]) begin
                    state_nxt = GAP;
                    valid_nxt = 1'b0;
                    grant_nxt = 4'b0000;
                end else if ((HOLD_MAX != 0) && (cnt == HOLD_LIM)) begin
                    state_nxt   = GAP;
                    valid_nxt   = 1'b0;
                    grant_nxt   = 4'b0000;
                    timeout_nxt = 1'b1;
                end else if (cnt != CNT_SAT) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 2'b00;
                ptr_nxt   = 2'd3;
                cnt_nxt   = '0;
                grant_nxt = 4'b0000;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 2'b00;
            ptr     <= 2'd3;
            cnt     <= '0;
            grant   <= 4'b0000;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            grant   <= grant_nxt;
            valid   <= valid_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign sel1 = sel[1];
    assign sel0 = sel[0];

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Bench for rr_mux_sel_arbiter: two instances (HOLD_MAX 15 and 3) share stimulus,
// a cycle model pushes expected outputs to a scoreboard checked after each edge.
module tb_rr_mux_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       sel1_a, sel0_a, valid_a, timeout_a;
    logic       sel1_b, sel0_b, valid_b, timeout_b;
    logic [3:0] grant_a, grant_b;
    logic [7:0] obs_a, obs_b;

    int total = 0;
    int bad   = 0;

    rr_mux_sel_arbiter #(.CNT_W(4), .HOLD_MAX(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel1(sel1_a), .sel0(sel0_a), .grant(grant_a),
        .valid(valid_a), .timeout(timeout_a)
    );

    rr_mux_sel_arbiter #(.CNT_W(4), .HOLD_MAX(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel1(sel1_b), .sel0(sel0_b), .grant(grant_b),
        .valid(valid_b), .timeout(timeout_b)
    );

    assign obs_a = {sel1_a, sel0_a, grant_a, valid_a, timeout_a};
    assign obs_b = {sel1_b, sel0_b, grant_b, valid_b, timeout_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model per instance: state 0=idle 1=grant 2=gap.
    int m_st  [2];
    int m_own [2];
    int m_ptr [2];
    int m_cnt [2];
    int m_to  [2];
    int hm    [2] = '{15, 3};

    logic [15:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = 0;
            m_own[k] = 0;
            m_ptr[k] = 3;
            m_cnt[k] = 0;
            m_to[k]  = 0;
        end
    endtask

    task automatic model_step(input int k);
        int w;
        w = -1;
        if (m_st[k] == 1) begin
            if (done || !req[m_own[k]]) begin
                m_st[k] = 2;
                m_to[k] = 0;
            end else if (hm[k] != 0 && m_cnt[k] == hm[k]) begin
                m_st[k] = 2;
                m_to[k] = 1;
            end else if (m_cnt[k] < 15) begin
                m_cnt[k]++;
            end
        end else begin
            m_to[k] = 0;
            for (int j = 1; j <= 4; j++)
                if (w < 0 && req[(m_ptr[k] + j) % 4]) w = (m_ptr[k] + j) % 4;
            if (w >= 0) begin
                m_st[k]  = 1;
                m_own[k] = w;
                m_ptr[k] = w;
                m_cnt[k] = 1;
            end else begin
                m_st[k] = 0;
            end
        end
    endtask

    function automatic logic [7:0] m_pack(input int k);
        logic [3:0] g;
        logic [1:0] s;
        s = 2'(m_own[k]);
        g = (m_st[k] == 1) ? (4'b0001 << s) : 4'b0000;
        return {s, g, (m_st[k] == 1), (m_to[k] != 0)};
    endfunction

    task automatic compare();
        logic [15:0] e;
        logic [7:0]  o, x;
        string       n;
        chk("sb_level", sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        for (int k = 0; k < 2; k++) begin
            o = (k == 0) ? obs_a : obs_b;
            x = (k == 0) ? e[7:0] : e[15:8];
            n = (k == 0) ? "a" : "b";
            chk({n, ".sel"},     o[7:6], x[7:6]);
            chk({n, ".grant"},   o[5:2], x[5:2]);
            chk({n, ".valid"},   o[1],   x[1]);
            chk({n, ".timeout"}, o[0],   x[0]);
            if (o[1]) begin
                chk({n, ".onehot"},       $onehot(o[5:2]), 1);
                chk({n, ".grant_at_sel"}, o[2 + o[7:6]],   1);
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        model_step(0);
        model_step(1);
        sb_q.push_back({m_pack(1), m_pack(0)});
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        #1;
        chk("rst_a", obs_a, 8'h00);
        chk("rst_b", obs_b, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order [$];
        logic [1:0] exp_order [5];
        logic       prev_v, d;
        int         gap, n_to, n_val, a_to;

        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;

        // Single requester ch2, released by done at edge 5, idle after edge 6.
        do_reset();
        cycle(4'b0100, 1'b0);
        chk("t1_sel", {sel1_a, sel0_a}, 2'b10);
        chk("t1_valid", valid_a, 1'b1);
        repeat (3) cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b1);
        chk("t1_release", valid_a, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("t1_idle", valid_a, 1'b0);

        // All requesting, done on the 3rd GRANT cycle: order 0,1,2,3,0 with one-cycle gaps.
        do_reset();
        prev_v = 1'b0;
        gap    = 0;
        n_to   = 0;
        for (int i = 0; i < 40 && order.size() < 5; i++) begin
            d = (m_st[0] == 1 && m_cnt[0] == 3);
            cycle(4'b1111, d);
            if (timeout_b) n_to++;
            if (valid_a) begin
                if (!prev_v) begin
                    order.push_back({sel1_a, sel0_a});
                    if (order.size() > 1) chk("t2_gap_len", gap, 1);
                end
                gap = 0;
            end else begin
                gap++;
            end
            prev_v = valid_a;
        end
        chk("t2_order_len", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("t2_owner%0d", i), order[i], exp_order[i]);
        chk("t4_done_beats_timeout", n_to, 0);

        // Sole requester ch1, no done: HOLD_MAX=3 instance times out and re-grants.
        do_reset();
        n_to  = 0;
        n_val = 0;
        a_to  = 0;
        repeat (8) begin
            cycle(4'b0010, 1'b0);
            if (timeout_b) n_to++;
            if (valid_b) n_val++;
            if (timeout_a) a_to++;
        end
        chk("t3_b_timeouts", n_to, 2);
        chk("t3_b_valid_cycles", n_val, 6);
        chk("t3_a_no_timeout", a_to, 0);

        // Owner ch2 drops its request with ch0 pending: pointer wraps to ch0.
        do_reset();
        cycle(4'b0100, 1'b0);
        cycle(4'b0101, 1'b0);
        cycle(4'b0101, 1'b0);
        chk("t5_hold_ch2", {sel1_a, sel0_a}, 2'b10);
        cycle(4'b0001, 1'b0);
        chk("t5_gap", valid_a, 1'b0);
        cycle(4'b0001, 1'b0);
        chk("t5_wrap_sel", {sel1_a, sel0_a}, 2'b00);
        chk("t5_wrap_grant", grant_a, 4'b0001);

        // Async reset while ch3 owns the mux, then ch3 granted again.
        do_reset();
        cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b0);
        chk("t6_pre_sel", {sel1_a, sel0_a}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_a", obs_a, 8'h00);
        chk("t6_async_b", obs_b, 8'h00);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1000, 1'b0);
        chk("t6_regrant_sel", {sel1_a, sel0_a}, 2'b11);
        chk("t6_regrant_valid", valid_a, 1'b1);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
